// File: rtl/cpu_axi_pkg.sv
//------------------------------------------------------------------------------
// Module : cpu_axi_pkg
// Brief  : Shared types, constants and request arbiter for cpu_axi_bridge.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4
    } state_t;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_t;

    typedef struct packed {
        logic inst;
        logic data;
    } grant_t;

    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [3:0] ID_INST_DEF = 4'd0;
    localparam logic [3:0] ID_DATA_DEF = 4'd1;

    // Data port always wins; instruction port is granted only when data is quiet.
    function automatic grant_t arbitrate(input logic inst_req, input logic data_req);
        grant_t g;
        g.data = data_req;
        g.inst = inst_req & ~data_req;
        return g;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_axi_bridge.sv
//------------------------------------------------------------------------------
// Module : cpu_axi_bridge
// Brief  : Two SRAM-like CPU ports (inst read-only, data r/w) onto one
//          single-beat AXI master with at most one outstanding transaction.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpu_axi_bridge
    import cpu_axi_pkg::*;
#(
    parameter logic [3:0] ID_INST = ID_INST_DEF,
    parameter logic [3:0] ID_DATA = ID_DATA_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic [3:0]  id_q, id_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        inst_data_ok_q, inst_data_ok_d;
    logic        data_data_ok_q, data_data_ok_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    grant_t      grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            owner_q        <= OWNER_INST;
            id_q           <= 4'd0;
            addr_q         <= 32'd0;
            wstrb_q        <= 4'd0;
            wdata_q        <= 32'd0;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            inst_data_ok_q <= 1'b0;
            data_data_ok_q <= 1'b0;
            inst_rdata_q   <= 32'd0;
            data_rdata_q   <= 32'd0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            id_q           <= id_d;
            addr_q         <= addr_d;
            wstrb_q        <= wstrb_d;
            wdata_q        <= wdata_d;
            aw_done_q      <= aw_done_d;
            w_done_q       <= w_done_d;
            inst_data_ok_q <= inst_data_ok_d;
            data_data_ok_q <= data_data_ok_d;
            inst_rdata_q   <= inst_rdata_d;
            data_rdata_q   <= data_rdata_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        id_d           = id_q;
        addr_d         = addr_q;
        wstrb_d        = wstrb_q;
        wdata_d        = wdata_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        inst_data_ok_d = 1'b0;
        data_data_ok_d = 1'b0;
        inst_rdata_d   = inst_rdata_q;
        data_rdata_d   = data_rdata_q;

        grant        = arbitrate(inst_req, data_req);
        inst_addr_ok = (state_q == ST_IDLE) & grant.inst;
        data_addr_ok = (state_q == ST_IDLE) & grant.data;

        arvalid = (state_q == ST_RD_ADDR);
        rready  = (state_q == ST_RD_DATA);
        awvalid = (state_q == ST_WR_REQ) & ~aw_done_q;
        wvalid  = (state_q == ST_WR_REQ) & ~w_done_q;
        bready  = (state_q == ST_WR_RESP);

        case (state_q)
            ST_IDLE: begin
                if (data_addr_ok) begin
                    addr_d    = data_addr;
                    wstrb_d   = data_wstrb;
                    wdata_d   = data_wdata;
                    owner_d   = OWNER_DATA;
                    id_d      = ID_DATA;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = data_wr ? ST_WR_REQ : ST_RD_ADDR;
                end else if (inst_addr_ok) begin
                    addr_d  = inst_addr;
                    owner_d = OWNER_INST;
                    id_d    = ID_INST;
                    state_d = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                if (arready) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                // Response routing relies on the captured owner, not on rid.
                if (rvalid) begin
                    if (owner_q == OWNER_INST) begin
                        inst_rdata_d   = rdata;
                        inst_data_ok_d = 1'b1;
                    end else begin
                        data_rdata_d   = rdata;
                        data_data_ok_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                aw_done_d = aw_done_q | (awvalid & awready);
                w_done_d  = w_done_q | (wvalid & wready);
                if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (bvalid) begin
                    data_data_ok_d = 1'b1;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign arid         = id_q;
    assign araddr       = addr_q;
    assign awid         = id_q;
    assign awaddr       = addr_q;
    assign wdata        = wdata_q;
    assign wstrb        = wstrb_q;
    assign inst_data_ok = inst_data_ok_q;
    assign data_data_ok = data_data_ok_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_axi_bridge.sv
//------------------------------------------------------------------------------
// Module : tb_cpu_axi_bridge
// Brief  : Directed cycle-exact bench for cpu_axi_bridge.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cpu_axi_bridge;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    int passed_cnt = 0;
    int total_cnt  = 0;

    cpu_axi_bridge dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .arid         (arid),
        .araddr       (araddr),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .rready       (rready),
        .awid         (awid),
        .awaddr       (awaddr),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wvalid       (wvalid),
        .wready       (wready),
        .bvalid       (bvalid),
        .bready       (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) passed_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        inst_req   = 1'b0;
        inst_addr  = 32'd0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_wstrb = 4'd0;
        data_addr  = 32'd0;
        data_wdata = 32'd0;
        arready    = 1'b0;
        rdata      = 32'd0;
        rvalid     = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;

        #1;
        chk("reset_valids", {arvalid, awvalid, wvalid, rready, bready, inst_data_ok, data_data_ok}, 64'd0);
        chk("reset_regs", {araddr, wstrb, arid, awid}, 64'd0);
        chk("reset_rdata", {inst_rdata, data_rdata}, 64'd0);
        tick();
        tick();
        reset = 1'b0;

        // Instruction read, zero-wait slave
        tick();
        inst_req = 1'b1; inst_addr = 32'h1C00_0000; arready = 1'b1;
        #1 chk("inst_c0_addr_ok", {inst_addr_ok, data_addr_ok}, 64'b10);
        tick();
        inst_req = 1'b0;
        #1 chk("inst_c1_ar", {arvalid, arid, araddr}, {27'd0, 1'b1, 4'd0, 32'h1C00_0000});
        chk("inst_c1_no_addr_ok", inst_addr_ok, 64'd0);
        tick();
        rvalid = 1'b1; rdata = 32'h0280_0406;
        #1 chk("inst_c2_rready", {rready, arvalid}, 64'b10);
        tick();
        rvalid = 1'b0;
        #1 chk("inst_c3_data_ok", {inst_data_ok, data_data_ok}, 64'b10);
        chk("inst_c3_rdata", inst_rdata, 64'h0280_0406);
        tick();
        #1 chk("inst_c4_pulse_end", inst_data_ok, 64'd0);

        // Simultaneous inst and data read requests
        inst_req = 1'b1; inst_addr = 32'h1C00_0010;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1C00_8000;
        #1 chk("sim_c0_grant", {inst_addr_ok, data_addr_ok}, 64'b01);
        tick();
        data_req = 1'b0;
        #1 chk("sim_c1_ar", {arvalid, arid, araddr}, {27'd0, 1'b1, 4'd1, 32'h1C00_8000});
        chk("sim_c1_inst_blocked", inst_addr_ok, 64'd0);
        tick();
        rvalid = 1'b1; rdata = 32'h1111_2222;
        tick();
        rvalid = 1'b0;
        #1 chk("sim_c3_data_ok", {data_data_ok, inst_data_ok, data_rdata}, {30'd0, 2'b10, 32'h1111_2222});
        chk("sim_c3_inst_accept", inst_addr_ok, 64'd1);
        tick();
        inst_req = 1'b0;
        #1 chk("sim_c4_ar_inst", {arvalid, arid, araddr}, {27'd0, 1'b1, 4'd0, 32'h1C00_0010});
        tick();
        rvalid = 1'b1; rdata = 32'h3333_4444;
        tick();
        rvalid = 1'b0;
        #1 chk("sim_c6_inst_ok", {inst_data_ok, inst_rdata}, {31'd0, 1'b1, 32'h3333_4444});
        chk("sim_c6_data_hold", data_rdata, 64'h1111_2222);

        // Write with AW accepted immediately and W delayed
        tick();
        awready = 1'b1; wready = 1'b0;
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h1C00_8004;
        data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'b0011;
        #1 chk("wr_c0_accept", data_addr_ok, 64'd1);
        tick();
        data_req = 1'b0; data_wr = 1'b0; data_wdata = 32'h0; data_wstrb = 4'h0;
        #1 chk("wr_c1_aw_w", {awvalid, wvalid, awid, awaddr}, {28'd0, 2'b11, 4'd1, 32'h1C00_8004});
        chk("wr_c1_wpayload", {wstrb, wdata}, {28'd0, 4'b0011, 32'hDEAD_BEEF});
        tick();
        #1 chk("wr_c2_aw_drop", {awvalid, wvalid, bready}, 64'b010);
        tick();
        #1 chk("wr_c3_w_hold", {wvalid, wstrb, wdata}, {27'd0, 1'b1, 4'b0011, 32'hDEAD_BEEF});
        tick();
        wready = 1'b1;
        #1 chk("wr_c4_w_hold", {wvalid, bready, wstrb, wdata}, {26'd0, 2'b10, 4'b0011, 32'hDEAD_BEEF});
        tick();
        wready = 1'b0; bvalid = 1'b1;
        #1 chk("wr_c5_bready", {awvalid, wvalid, bready, data_data_ok}, 64'b0010);
        tick();
        bvalid = 1'b0;
        #1 chk("wr_c6_data_ok", {data_data_ok, bready}, 64'b10);
        awready = 1'b0;

        // Read with address backpressure; requests pending during the stall
        tick();
        arready = 1'b0;
        data_req = 1'b1; data_addr = 32'h1C00_800C;
        #1 chk("bp_accept", data_addr_ok, 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            data_addr = 32'hBAD0_0000 + i; inst_req = 1'b1;
            #1 chk("bp_stall", {arvalid, inst_addr_ok, data_addr_ok, araddr}, {29'd0, 3'b100, 32'h1C00_800C});
        end
        tick();
        arready = 1'b1;
        #1 chk("bp_release", {arvalid, araddr}, {31'd0, 1'b1, 32'h1C00_800C});
        tick();
        inst_req = 1'b0; data_req = 1'b0; arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h5555_6666;
        tick();
        rvalid = 1'b0;
        #1 chk("bp_done", {data_data_ok, inst_data_ok, data_rdata}, {30'd0, 2'b10, 32'h5555_6666});

        // Asynchronous reset while waiting for read data
        arready = 1'b1;
        tick();
        data_req = 1'b1; data_addr = 32'h1C00_8010;
        tick();
        data_req = 1'b0;
        tick();
        #1 chk("rst_in_rd_data", rready, 64'd1);
        #1 reset = 1'b1;
        #1 chk("rst_async_valids", {rready, arvalid, awvalid, wvalid, bready}, 64'd0);
        chk("rst_async_regs", {araddr, data_rdata}, 64'd0);
        rvalid = 1'b1; rdata = 32'hFFFF_0000;
        tick();
        rvalid = 1'b0;
        #1 chk("rst_no_data_ok", {data_data_ok, inst_data_ok}, 64'd0);
        reset = 1'b0;
        tick();
        inst_req = 1'b1; inst_addr = 32'h1C00_0020;
        #1 chk("rst_after_accept", inst_addr_ok, 64'd1);
        tick();
        inst_req = 1'b0;
        #1 chk("rst_after_ar", {arvalid, arid, araddr}, {27'd0, 1'b1, 4'd0, 32'h1C00_0020});
        tick();
        rvalid = 1'b1; rdata = 32'h7777_8888;
        tick();
        rvalid = 1'b0;
        #1 chk("rst_after_done", {inst_data_ok, inst_rdata}, {31'd0, 1'b1, 32'h7777_8888});

        // Back-to-back data reads, zero-wait slave, data_req held high
        data_req = 1'b1; data_wr = 1'b0; arready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_addr = 32'h1C00_9000 + 32'(4 * i);
            #1 chk("b2b_accept", data_addr_ok, 64'd1);
            if (i > 0)
                chk("b2b_data_ok", {data_data_ok, data_rdata}, {31'd0, 1'b1, 32'hA000_0000 + 32'(i - 1)});
            tick();
            #1 chk("b2b_ar", {arvalid, arid, araddr}, {27'd0, 1'b1, 4'd1, 32'h1C00_9000 + 32'(4 * i)});
            tick();
            rvalid = 1'b1; rdata = 32'hA000_0000 + 32'(i);
            tick();
            rvalid = 1'b0;
        end
        data_req = 1'b0;
        #1 chk("b2b_last", {data_data_ok, data_rdata}, {31'd0, 1'b1, 32'hA000_0002});
        chk("b2b_inst_untouched", inst_rdata, 64'h7777_8888);

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
